uba_intr: RTL and testbench

Unibus Adapter interrupt responder: the bus-side counterpart to the per-device interrupt requesters (RH11, DZ11, LP20, …). It collects level-sensitive device IRQs tagged with a Unibus bus-request level (BR4–BR7) and maps them onto the two KS10 PI levels programmed in the UBA status register. It answers the CPU interrupt-acknowledge cycle by arbitrating among requesters at the acknowledged level. It returns the winner's vector and pulses that device's IACK, which clears the device's interrupt flip-flop.

---
 rtl/uba_intr_if.sv | 27 ++
 rtl/uba_intr.sv | 157 +++++++++++++++
 tb/tb_uba_intr.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/uba_intr_if.sv
// Unibus adapter interrupt bundle: device request/vector lines, UBA PI-level setup and CPU acknowledge bus.
// master = devices/CPU side driving requests and acknowledges; slave = uba_intr.
interface uba_intr_if #(
    parameter int NDEV = 8
);
    logic [NDEV-1:0]    devIRQ;
    logic [2*NDEV-1:0]  devBR;
    logic [16*NDEV-1:0] devVECT;
    logic [2:0]         ubaPIH;
    logic [2:0]         ubaPIL;
    logic               busACKN;
    logic [2:0]         busACKLEV;
    logic [6:0]         busINTR;
    logic [15:0]        busVECT;
    logic               busVECTVLD;
    logic [NDEV-1:0]    devIACK;

    modport master (
        output devIRQ, devBR, devVECT, ubaPIH, ubaPIL, busACKN, busACKLEV,
        input  busINTR, busVECT, busVECTVLD, devIACK
    );

    modport slave (
        input  devIRQ, devBR, devVECT, ubaPIH, ubaPIL, busACKN, busACKLEV,
        output busINTR, busVECT, busVECTVLD, devIACK
    );
endinterface

// File: rtl/uba_intr.sv
// UBA interrupt responder: maps BR4-BR7 device IRQs onto two PI levels and answers the acknowledge cycle.
// Latency: IRQ->busINTR 1 clk; ack edge->vector/IACK 2 clks. No backpressure: CPU holds busACKN until vector taken.
// Tie-break among equal BR: fixed lowest index, or round-robin when UBAINTR_RR_EN is defined.
module uba_intr #(
    parameter int NDEV = 8
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     devRESET,
    uba_intr_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ARB, RESP, HOLD} state_t;

    state_t          state_q, state_d;
    logic            ack_q;
    logic [6:0]      intr_q, intr_d;
    logic [15:0]     vect_q, vect_d;
    logic            vld_q, vld_d;
    logic [NDEV-1:0] iack_q, iack_d;

    logic            clr;
    logic [NDEV-1:0] hi_irq, lo_irq, cand, ok;
    logic            hi_match, lo_match, any_cand;
    logic [1:0]      max_br;
    logic [3:0]      win_idx;
    logic [15:0]     win_vect;

    assign clr = rst | devRESET;

    always_comb begin
        hi_irq = '0;
        lo_irq = '0;
        for (int i = 0; i < NDEV; i++) begin
            hi_irq[i] = bus.devIRQ[i] &  bus.devBR[2*i+1];
            lo_irq[i] = bus.devIRQ[i] & ~bus.devBR[2*i+1];
        end
    end

    // A group whose PI field is zero is disabled for both requests and acknowledges.
    assign hi_match = (bus.ubaPIH != 3'd0) && (bus.ubaPIH == bus.busACKLEV);
    assign lo_match = (bus.ubaPIL != 3'd0) && (bus.ubaPIL == bus.busACKLEV);
    assign cand     = (hi_irq & {NDEV{hi_match}}) | (lo_irq & {NDEV{lo_match}});
    assign any_cand = |cand;

    always_comb begin
        intr_d = '0;
        if ((|hi_irq) && (bus.ubaPIH != 3'd0))
            intr_d[bus.ubaPIH - 3'd1] = 1'b1;
        if ((|lo_irq) && (bus.ubaPIL != 3'd0))
            intr_d[bus.ubaPIL - 3'd1] = 1'b1;
    end

    always_comb begin
        max_br = 2'd0;
        for (int i = 0; i < NDEV; i++)
            if (cand[i] && (bus.devBR[2*i +: 2] > max_br))
                max_br = bus.devBR[2*i +: 2];
        ok = '0;
        for (int i = 0; i < NDEV; i++)
            ok[i] = cand[i] && (bus.devBR[2*i +: 2] == max_br);
    end

`ifdef UBAINTR_RR_EN
    logic [3:0] ptr_q [4];
    logic [3:0] start;
    logic [3:0] ptr_nxt;
    logic       found;

    assign start = ptr_q[max_br];

    // Two passes: indices at/after the pointer first, then wrap to the low ones.
    always_comb begin
        win_idx = '0;
        found   = 1'b0;
        for (int i = 0; i < NDEV; i++)
            if (!found && (i >= int'(start)) && ok[i]) begin
                win_idx = 4'(i);
                found   = 1'b1;
            end
        for (int i = 0; i < NDEV; i++)
            if (!found && ok[i]) begin
                win_idx = 4'(i);
                found   = 1'b1;
            end
    end

    assign ptr_nxt = (int'(win_idx) + 1 >= NDEV) ? 4'd0 : win_idx + 4'd1;

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int b = 0; b < 4; b++)
                ptr_q[b] <= 4'd0;
        end else if (state_q == ARB && any_cand) begin
            ptr_q[max_br] <= ptr_nxt;
        end
    end
`else
    always_comb begin
        win_idx = '0;
        for (int i = NDEV - 1; i >= 0; i--)
            if (ok[i])
                win_idx = 4'(i);
    end
`endif

    assign win_vect = bus.devVECT[16*win_idx +: 16];

    always_comb begin
        state_d = state_q;
        vect_d  = vect_q;
        vld_d   = vld_q;
        iack_d  = '0;
        case (state_q)
            IDLE: if (bus.busACKN && !ack_q) state_d = ARB;
            ARB: begin
                state_d = RESP;
                vld_d   = 1'b1;
                vect_d  = any_cand ? win_vect : 16'd0;
                if (any_cand)
                    iack_d = {{(NDEV-1){1'b0}}, 1'b1} << win_idx;
            end
            RESP: state_d = HOLD;
            HOLD: begin
                // Registered ack level, so release lands one clock after busACKN is seen low.
                if (!ack_q) begin
                    state_d = IDLE;
                    vld_d   = 1'b0;
                    vect_d  = 16'd0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
            intr_q  <= '0;
            vect_q  <= '0;
            vld_q   <= 1'b0;
            iack_q  <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= bus.busACKN;
            intr_q  <= intr_d;
            vect_q  <= vect_d;
            vld_q   <= vld_d;
            iack_q  <= iack_d;
        end
    end

    assign bus.busINTR    = intr_q;
    assign bus.busVECT    = vect_q;
    assign bus.busVECTVLD = vld_q;
    assign bus.devIACK    = iack_q;
endmodule

// File: tb/tb_uba_intr.sv
// Directed bench for uba_intr: PI mapping, acknowledge arbitration, hold/release timing and reset abort.
module tb_uba_intr;
    localparam int NDEV = 8;

    logic clk = 1'b0;
    logic rst;
    logic devRESET;
    int   checks = 0;
    int   errors = 0;

    uba_intr_if #(.NDEV(NDEV)) bus_if ();

    uba_intr #(.NDEV(NDEV)) dut (
        .clk      (clk),
        .rst      (rst),
        .devRESET (devRESET),
        .bus      (bus_if.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] vec(input int i);
        return 16'o244 + 16'(4 * i);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_br(input int i, input logic [1:0] v);
        bus_if.devBR[2*i +: 2] = v;
    endtask

    // Returns with the DUT in RESP (vector valid, IACK pulsing).
    task automatic ack(input logic [2:0] lev);
        bus_if.busACKLEV = lev;
        bus_if.busACKN   = 1'b1;
        tick();
        tick();
    endtask

    task automatic release_ack();
        bus_if.busACKN = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        int exp_w;
        rst              = 1'b1;
        devRESET         = 1'b0;
        bus_if.devIRQ    = '0;
        bus_if.devBR     = '0;
        bus_if.ubaPIH    = 3'd0;
        bus_if.ubaPIL    = 3'd0;
        bus_if.busACKN   = 1'b0;
        bus_if.busACKLEV = 3'd0;
        for (int i = 0; i < NDEV; i++)
            bus_if.devVECT[16*i +: 16] = vec(i);
        tick();
        tick();
        chk("rst_intr", 32'(bus_if.busINTR), 32'd0);
        chk("rst_vld",  32'(bus_if.busVECTVLD), 32'd0);
        chk("rst_vect", 32'(bus_if.busVECT), 32'd0);
        chk("rst_iack", 32'(bus_if.devIACK), 32'd0);
        rst = 1'b0;

        // Device 2 at BR5 -> low group -> PI6
        bus_if.ubaPIH = 3'd5;
        bus_if.ubaPIL = 3'd6;
        set_br(2, 2'd1);
        bus_if.devIRQ = 8'b0000_0100;
        tick();
        chk("t1_intr", 32'(bus_if.busINTR), 32'b010_0000);
        bus_if.busACKLEV = 3'd6;
        bus_if.busACKN   = 1'b1;
        tick();
        chk("t1_arb_vld", 32'(bus_if.busVECTVLD), 32'd0);
        chk("t1_arb_iack", 32'(bus_if.devIACK), 32'd0);
        tick();
        chk("t1_vld",  32'(bus_if.busVECTVLD), 32'd1);
        chk("t1_vect", 32'(bus_if.busVECT), 32'o254);
        chk("t1_iack", 32'(bus_if.devIACK), 32'b0000_0100);
        tick();
        chk("t1_iack_off", 32'(bus_if.devIACK), 32'd0);
        chk("t1_hold_vld", 32'(bus_if.busVECTVLD), 32'd1);
        bus_if.busACKN = 1'b0;
        tick();
        chk("t1_rel1_vld", 32'(bus_if.busVECTVLD), 32'd1);
        tick();
        chk("t1_rel2_vld",  32'(bus_if.busVECTVLD), 32'd0);
        chk("t1_rel2_vect", 32'(bus_if.busVECT), 32'd0);
        bus_if.devIRQ = '0;
        tick();

        // BR5 beats BR4 within the low group, then the BR4 device gets its turn
        set_br(1, 2'd0);
        set_br(3, 2'd1);
        bus_if.devIRQ = 8'b0000_1010;
        tick();
        ack(3'd6);
        chk("t2a_iack", 32'(bus_if.devIACK), 32'b0000_1000);
        chk("t2a_vect", 32'(bus_if.busVECT), 32'(vec(3)));
        release_ack();
        bus_if.devIRQ = 8'b0000_0010;
        tick();
        ack(3'd6);
        chk("t2b_iack", 32'(bus_if.devIACK), 32'b0000_0010);
        chk("t2b_vect", 32'(bus_if.busVECT), 32'(vec(1)));
        release_ack();

        // Acknowledge at an unmapped level: passive release
        ack(3'd3);
        chk("t3_vld",  32'(bus_if.busVECTVLD), 32'd1);
        chk("t3_vect", 32'(bus_if.busVECT), 32'd0);
        chk("t3_iack", 32'(bus_if.devIACK), 32'd0);
        release_ack();
        bus_if.devIRQ = '0;
        tick();

        // Requester drops after ARB, CPU holds acknowledge for 5 extra cycles
        set_br(0, 2'd3);
        bus_if.devIRQ = 8'b0000_0001;
        tick();
        chk("t4_intr", 32'(bus_if.busINTR), 32'b001_0000);
        ack(3'd5);
        bus_if.devIRQ = '0;
        chk("t4_iack", 32'(bus_if.devIACK), 32'b0000_0001);
        chk("t4_vect", 32'(bus_if.busVECT), 32'(vec(0)));
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t4_hold_vld", 32'(bus_if.busVECTVLD), 32'd1);
        end
        bus_if.busACKN = 1'b0;
        tick();
        chk("t4_rel1_vld", 32'(bus_if.busVECTVLD), 32'd1);
        tick();
        chk("t4_rel2_vld", 32'(bus_if.busVECTVLD), 32'd0);

        // Reset in the middle of RESP
        bus_if.devIRQ = 8'b0000_0100;
        tick();
        ack(3'd6);
        chk("t5_resp_iack", 32'(bus_if.devIACK), 32'b0000_0100);
        rst            = 1'b1;
        bus_if.busACKN = 1'b0;
        tick();
        chk("t5_rst_intr", 32'(bus_if.busINTR), 32'd0);
        chk("t5_rst_vld",  32'(bus_if.busVECTVLD), 32'd0);
        chk("t5_rst_vect", 32'(bus_if.busVECT), 32'd0);
        chk("t5_rst_iack", 32'(bus_if.devIACK), 32'd0);
        rst = 1'b0;
        tick();
        tick();
        chk("t5_post_iack", 32'(bus_if.devIACK), 32'd0);
        chk("t5_post_vld",  32'(bus_if.busVECTVLD), 32'd0);
        chk("t5_post_intr", 32'(bus_if.busINTR), 32'b010_0000);
        devRESET = 1'b1;
        tick();
        chk("t5_devrst_intr", 32'(bus_if.busINTR), 32'd0);
        devRESET      = 1'b0;
        bus_if.devIRQ = '0;
        tick();

        // PI field zero disables the group; equal fields OR onto one bit
        set_br(7, 2'd3);
        bus_if.ubaPIH = 3'd0;
        bus_if.devIRQ = 8'b1000_0000;
        tick();
        chk("t6_pih0_intr", 32'(bus_if.busINTR), 32'd0);
        bus_if.ubaPIH = 3'd3;
        tick();
        chk("t6_pih3_intr", 32'(bus_if.busINTR), 32'b000_0100);
        bus_if.ubaPIH = 3'd4;
        bus_if.ubaPIL = 3'd4;
        set_br(1, 2'd0);
        bus_if.devIRQ = 8'b1000_0010;
        tick();
        chk("t6_same_intr", 32'(bus_if.busINTR), 32'b000_1000);
        bus_if.devIRQ = '0;
        bus_if.ubaPIH = 3'd5;
        bus_if.ubaPIL = 3'd6;
        tick();

        // Two persistent BR6 requesters: tie-break sequence
        set_br(0, 2'd2);
        set_br(4, 2'd2);
        bus_if.devIRQ = 8'b0001_0001;
        tick();
        for (int k = 0; k < 4; k++) begin
`ifdef UBAINTR_RR_EN
            exp_w = (k % 2 == 1) ? 4 : 0;
`else
            exp_w = 0;
`endif
            ack(3'd5);
            chk("t7_iack", 32'(bus_if.devIACK), 32'd1 << exp_w);
            chk("t7_vect", 32'(bus_if.busVECT), 32'(vec(exp_w)));
            release_ack();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
